// File: rtl/store_buffer.sv
// Posted-write store buffer between the core MEM stage and data memory.
// Stores queue in a FIFO and drain in order; loads wait for the drain, then issue.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        sb_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssueW,
    StIssueR,
    StWaitHi,
    StWaitLo,
    StLoadDone
  } state_e;

  state_e state_q, state_d;

  logic [31:0] fifo_addr_q [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];
  logic [3:0]  fifo_mask_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        is_load_q, is_load_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        sb_empty_q, sb_empty_d;

  logic full;
  logic push;
  logic pop;

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign full = (count_q == CntW'(DEPTH));
  assign push = cpu_memwrite & ~full;
  assign pop  = (state_q == StWaitLo) & ~mem_clk_stall & ~is_load_q;

  assign cpu_stall = (cpu_memwrite & full) | (cpu_memread & (state_q != StLoadDone));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_data_d   = rd_data_q;
    unique case (state_q)
      StIdle: begin
        // Memory still busy (e.g. after a mid-access reset) blocks any issue.
        if (!mem_clk_stall) begin
          if (count_q != '0) begin
            state_d     = StIssueW;
            is_load_d   = 1'b0;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
            mem_mask_d  = fifo_mask_q[rd_ptr_q];
            mem_we_d    = 1'b1;
          end else if (cpu_memread) begin
            state_d     = StIssueR;
            is_load_d   = 1'b1;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_write_data;
            mem_mask_d  = cpu_sign_mask;
            mem_re_d    = 1'b1;
          end
        end
      end
      StIssueW, StIssueR: state_d = StWaitHi;
      StWaitHi: begin
        if (mem_clk_stall) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!mem_clk_stall) begin
          if (is_load_q) begin
            rd_data_d = mem_read_data;
            state_d   = StLoadDone;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLoadDone: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  assign sb_empty_d = (count_d == '0) && (state_d == StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      is_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_mask_q  <= '0;
      rd_data_q   <= '0;
      sb_empty_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      is_load_q   <= is_load_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_mask_q  <= mem_mask_d;
      rd_data_q   <= rd_data_d;
      sb_empty_q  <= sb_empty_d;
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_write_data;
      fifo_mask_q[wr_ptr_q] <= cpu_sign_mask;
    end
  end

  assign cpu_read_data  = rd_data_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memwrite   = mem_we_q;
  assign mem_memread    = mem_re_q;
  assign mem_sign_mask  = mem_mask_q;
  assign sb_empty       = sb_empty_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a behavioural memory slave, a word-level
// reference memory, and a monitor that checks every memory access and load result.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;
  logic        sb_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_write_data (cpu_write_data),
    .cpu_memwrite   (cpu_memwrite),
    .cpu_memread    (cpu_memread),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall),
    .sb_empty       (sb_empty)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t        exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int last_wr_cyc = 0;
  int acc_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return ~a;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    return ~a;
  endfunction

  // Memory slave: busy from the cycle after a pulse for two cycles, then completes.
  logic        busy = 1'b0;
  int          bcnt = 0;
  logic        pend_we;
  logic [31:0] pend_addr;
  logic [31:0] pend_data;
  initial mem_read_data = '0;
  assign mem_clk_stall = busy;

  always @(posedge clk) begin
    if (mem_memwrite || mem_memread) begin
      busy      <= 1'b1;
      bcnt      <= 1;
      pend_we   <= mem_memwrite;
      pend_addr <= mem_addr;
      pend_data <= mem_write_data;
    end else if (busy && bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else if (busy) begin
      busy <= 1'b0;
      if (pend_we) slave_mem[pend_addr] = pend_data;
      else mem_read_data <= slave_read(pend_addr);
    end
  end

  // Monitor
  logic prev_pulse = 1'b0;
  logic prev_stall = 1'b0;
  txn_t mon_e;
  logic [31:0] mon_rd;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_memwrite || mem_memread) begin
        check("pulse_single_cycle", 32'(prev_pulse), 32'd0);
        check("no_issue_while_busy", 32'(prev_stall), 32'd0);
        if (mem_memwrite) begin
          wr_pulses++;
          last_wr_cyc = cyc;
        end
        if (exp_mem_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_mem_access: got addr %h expected none", mem_addr);
        end else begin
          mon_e = exp_mem_q.pop_front();
          check("mem_kind", {mem_memread, mem_memwrite}, {~mon_e.we, mon_e.we});
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_mask", 32'(mem_sign_mask), 32'(mon_e.mask));
          if (mon_e.we) check("mem_data", mem_write_data, mon_e.data);
        end
      end
      if (cpu_memread && !cpu_stall) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_load_done: got data %h expected none", cpu_read_data);
        end else begin
          mon_rd = exp_rd_q.pop_front();
          check("cpu_read_data", cpu_read_data, mon_rd);
        end
      end
    end
    prev_pulse = mem_memwrite | mem_memread;
    prev_stall = mem_clk_stall;
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int stalls);
    txn_t t;
    int n;
    stalls = 0;
    n = 0;
    cpu_addr = a;
    cpu_write_data = d;
    cpu_sign_mask = m;
    cpu_memwrite = 1'b1;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      n++;
      if (n > 200) begin
        $display("FAIL store_accept_timeout: got stall for %0d cycles expected accept", n);
        $fatal(1);
      end
    end
    acc_cyc = cyc;
    t.we = 1'b1;
    t.addr = a;
    t.data = d;
    t.mask = m;
    exp_mem_q.push_back(t);
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, output int stalls);
    txn_t t;
    int n;
    stalls = 0;
    n = 0;
    cpu_addr = a;
    cpu_sign_mask = m;
    cpu_memread = 1'b1;
    t.we = 1'b0;
    t.addr = a;
    t.data = '0;
    t.mask = m;
    exp_mem_q.push_back(t);
    exp_rd_q.push_back(ref_read(a));
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      n++;
      if (n > 200) begin
        $display("FAIL load_timeout: got stall for %0d cycles expected completion", n);
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
    cpu_memread = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!sb_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb_empty), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_pulses", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    check("rst_mem_mask", 32'(mem_sign_mask), 32'd0);
    check("rst_cpu_read_data", cpu_read_data, 32'd0);
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
  endtask

  initial begin
    int st;
    int w0;
    int k;
    int n;
    cpu_addr = '0;
    cpu_write_data = '0;
    cpu_memwrite = 1'b0;
    cpu_memread = 1'b0;
    cpu_sign_mask = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single store on an empty buffer
    w0 = wr_pulses;
    do_store(32'h100, 32'hDEADBEEF, 4'b0111, st);
    check("t1_store_stall", st, 0);
    wait_idle("t1_sb_empty");
    check("t1_pulse_delay", last_wr_cyc, acc_cyc + 2);
    check("t1_pulse_count", wr_pulses - w0, 1);

    // Five back-to-back stores; the fifth waits for the first pop
    w0 = wr_pulses;
    for (int i = 0; i < 5; i++) begin
      do_store(32'(i * 4), $urandom, 4'($urandom_range(0, 15)), st);
      if (i < 4) check("t2_store_stall", st, 0);
      else check("t2_full_stall", st, 2);
    end
    wait_idle("t2_sb_empty");
    check("t2_pulse_count", wr_pulses - w0, 5);

    // Two stores then a load that must see the drained data
    do_store(32'h4, 32'hCAFE0004, 4'b0010, st);
    do_store(32'h8, 32'hCAFE0008, 4'b0010, st);
    do_load(32'h4, 4'b0010, st);
    wait_idle("t3_sb_empty");

    // Load on an empty buffer
    slave_mem[32'h300] = 32'h12345678;
    ref_mem[32'h300] = 32'h12345678;
    do_load(32'h300, 4'b0010, st);
    check("t4_load_stall", st, 5);
    check("t4_read_value", cpu_read_data, 32'h12345678);
    wait_idle("t4_sb_empty");

    // Random mix of stores and loads with gaps; wraps the FIFO many times
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7)
        do_store({26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                 4'($urandom_range(0, 15)), st);
      else
        do_load({26'd0, 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom_range(0, 15)), st);
      k = $urandom_range(0, 2);
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
    end
    wait_idle("t5_sb_empty");

    // Reset while the first of three queued stores waits for completion
    do_store(32'h500, 32'h55550500, 4'b1111, st);
    do_store(32'h504, 32'h55550504, 4'b1111, st);
    do_store(32'h508, 32'h55550508, 4'b1111, st);
    n = 0;
    while (!mem_clk_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_mem_busy_seen", 32'(mem_clk_stall), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outs();
    exp_mem_q.delete();
    ref_mem.delete(32'h504);
    ref_mem.delete(32'h508);
    @(negedge clk);
    check_reset_outs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_store(32'h2000, 32'h000000AB, 4'b0001, st);
    check("t6_led_store_stall", st, 0);
    wait_idle("t6_sb_empty");
    do_load(32'h2000, 4'b0001, st);
    do_load(32'h504, 4'b1111, st);
    wait_idle("t6_final_idle");

    check("exp_mem_q_drained", exp_mem_q.size(), 0);
    check("exp_rd_q_drained", exp_rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
